// File: rtl/exhaustive_pattern_sequencer_if.sv
// Bus between the test controller (which also hosts the CUT) and the
// exhaustive pattern sequencer.
//   master : controller/CUT side. It drives start, abort, golden_sig,
//            cut_resp and exp_resp, and observes pat and the result outputs.
//   slave  : sequencer side. It is the mirror of master.
// Signals:
//   start/abort      run control
//   golden_sig       expected final MISR signature
//   pat              vector applied to the CUT inputs
//   cut_resp         CUT outputs for pat
//   exp_resp         expected CUT outputs for pat
//   busy/done        run status; done is a one-cycle completion pulse
//   result_valid     results below are from a completed run
//   pass             fail_cnt==0 and signature==golden_sig
//   signature        MISR contents
//   fail_cnt         number of mismatching patterns
//   first_fail_*     first mismatching pattern index and its valid flag
interface exhaustive_pattern_sequencer_if #(
  parameter int N_IN   = 15,
  parameter int N_OUT  = 2,
  parameter int MISR_W = 16
);
  logic              start;
  logic              abort;
  logic [MISR_W-1:0] golden_sig;
  logic [N_IN-1:0]   pat;
  logic [N_OUT-1:0]  cut_resp;
  logic [N_OUT-1:0]  exp_resp;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic              pass;
  logic [MISR_W-1:0] signature;
  logic [N_IN:0]     fail_cnt;
  logic              first_fail_valid;
  logic [N_IN-1:0]   first_fail_pat;

  modport master (
    output start, abort, golden_sig, cut_resp, exp_resp,
    input  pat, busy, done, result_valid, pass, signature, fail_cnt,
           first_fail_valid, first_fail_pat
  );

  modport slave (
    input  start, abort, golden_sig, cut_resp, exp_resp,
    output pat, busy, done, result_valid, pass, signature, fail_cnt,
           first_fail_valid, first_fail_pat
  );
endinterface

// File: rtl/exhaustive_pattern_sequencer.sv
// Exhaustive pattern sequencer for a combinational circuit-under-test.
// After start, every input vector 0 .. 2^N_IN-1 is applied in ascending
// order. Each vector is held for one APPLY cycle, SETTLE_CYC settle cycles
// and one CAPTURE cycle. On the capture edge the CUT response is folded
// into a MISR and compared with the expected response. When the last
// vector has been captured the block spends one DONE cycle, then publishes
// done/result_valid/pass on the edge that returns it to IDLE.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  exhaustive_pattern_sequencer_if.slave (control, CUT and results)
module exhaustive_pattern_sequencer #(
  parameter int          N_IN       = 15,
  parameter int          N_OUT      = 2,
  parameter int          SETTLE_CYC = 1,
  parameter int          MISR_W     = 16,
  parameter logic [31:0] MISR_POLY  = 32'h0000_100B
) (
  input  logic clk,
  input  logic rst,
  exhaustive_pattern_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int                SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]     SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [MISR_W-1:0] POLY        = MISR_W'(MISR_POLY);

  state_t            state, state_nxt;
  logic [SW-1:0]     settle_cnt;

  logic              do_start;
  logic              do_capture;
  logic              do_finish;

  logic [N_IN-1:0]   pat_r;
  logic [MISR_W-1:0] sig_r;
  logic [N_IN:0]     fail_cnt_r;
  logic              ffv_r;
  logic [N_IN-1:0]   ffp_r;
  logic              busy_r;
  logic              done_r;
  logic              rv_r;
  logic              pass_r;

  // One MISR step: shift, fold in the feedback taps when the MSB falls
  // out, then XOR the zero-extended response into the low bits.
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [N_OUT-1:0]  resp);
    misr_next = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? POLY : '0) ^ MISR_W'(resp);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // abort only matters while a run is active; in IDLE it also vetoes start.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (bus.start && !bus.abort) state_nxt = S_APPLY;
      S_APPLY:   if (bus.abort)               state_nxt = S_IDLE;
                 else if (SETTLE_CYC > 0)     state_nxt = S_SETTLE;
                 else                         state_nxt = S_CAPTURE;
      S_SETTLE:  if (bus.abort)               state_nxt = S_IDLE;
                 else if (settle_cnt == SETTLE_LAST) state_nxt = S_CAPTURE;
      S_CAPTURE: if (bus.abort)               state_nxt = S_IDLE;
                 else if (&pat_r)             state_nxt = S_DONE;
                 else                         state_nxt = S_APPLY;
      S_DONE:                                 state_nxt = S_IDLE;
      default:                                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    do_start   = (state == S_IDLE) && bus.start && !bus.abort;
    do_capture = (state == S_CAPTURE) && !bus.abort;
    do_finish  = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_SETTLE) settle_cnt <= '0;
    else                          settle_cnt <= settle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r      <= '0;
      sig_r      <= '0;
      fail_cnt_r <= '0;
      ffv_r      <= 1'b0;
      ffp_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rv_r       <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nxt == S_APPLY) || (state_nxt == S_SETTLE) ||
                (state_nxt == S_CAPTURE);
      if (do_start) begin
        pat_r      <= '0;
        sig_r      <= '0;
        fail_cnt_r <= '0;
        ffv_r      <= 1'b0;
        ffp_r      <= '0;
        rv_r       <= 1'b0;
        pass_r     <= 1'b0;
      end
      if (do_capture) begin
        sig_r <= misr_next(sig_r, bus.cut_resp);
        if (bus.cut_resp != bus.exp_resp) begin
          fail_cnt_r <= fail_cnt_r + 1'b1;
          if (!ffv_r) begin
            ffv_r <= 1'b1;
            ffp_r <= pat_r;
          end
        end
        // The last vector stays on pat; it is not wrapped back to zero.
        if (!(&pat_r)) pat_r <= pat_r + 1'b1;
      end
      // The DONE cycle sees the post-capture signature and count.
      if (do_finish) begin
        done_r <= 1'b1;
        rv_r   <= 1'b1;
        pass_r <= (fail_cnt_r == '0) && (sig_r == bus.golden_sig);
      end
    end
  end

  assign bus.pat              = pat_r;
  assign bus.signature        = sig_r;
  assign bus.fail_cnt         = fail_cnt_r;
  assign bus.first_fail_valid = ffv_r;
  assign bus.first_fail_pat   = ffp_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.result_valid     = rv_r;
  assign bus.pass             = pass_r;

endmodule

// File: tb/tb_exhaustive_pattern_sequencer.sv
// Bench for exhaustive_pattern_sequencer: a 3-input, 2-output CUT model,
// one sequencer with one settle cycle and one with none.
module tb_exhaustive_pattern_sequencer;
  localparam int          N_IN   = 3;
  localparam int          N_OUT  = 2;
  localparam int          MISR_W = 16;
  localparam int          NPAT   = 1 << N_IN;
  localparam logic [15:0] POLY   = 16'h100B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exhaustive_pattern_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .MISR_W(MISR_W)) bus1 ();
  exhaustive_pattern_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .MISR_W(MISR_W)) bus0 ();

  exhaustive_pattern_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYC(1),
    .MISR_W(MISR_W), .MISR_POLY(32'h100B)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  exhaustive_pattern_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYC(0),
    .MISR_W(MISR_W), .MISR_POLY(32'h100B)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Per-pattern corruption of exp_resp for dut1; 0 means exp_resp is correct.
  logic [1:0] flip [NPAT];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [1:0] cut_fn(input int p);
    logic [2:0] v;
    v = 3'(p);
    cut_fn = {logic'((p % 3) == 1), ^v};
  endfunction

  always_comb begin
    bus1.cut_resp = cut_fn(int'(bus1.pat));
    bus1.exp_resp = cut_fn(int'(bus1.pat)) ^ flip[bus1.pat];
    bus0.cut_resp = cut_fn(int'(bus0.pat));
    bus0.exp_resp = cut_fn(int'(bus0.pat));
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Whole-run expectation straight from the rules: signature over all
  // patterns in ascending order, mismatch count and first mismatch.
  function automatic void model(output logic [15:0] sig, output int fails, output int first);
    sig   = '0;
    fails = 0;
    first = -1;
    for (int p = 0; p < NPAT; p++) begin
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0) ^ {14'h0, cut_fn(p)};
      if (flip[p] != 2'b00) begin
        fails++;
        if (first < 0) first = p;
      end
    end
  endfunction

  function automatic int flips_below(input int p);
    flips_below = 0;
    for (int q = 0; q < p; q++) if (flip[q] != 2'b00) flips_below++;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_pat"},  bus1.pat, 0);
    check({tag, "_sig"},  bus1.signature, 0);
    check({tag, "_fcnt"}, bus1.fail_cnt, 0);
    check({tag, "_ffv"},  bus1.first_fail_valid, 0);
    check({tag, "_ffp"},  bus1.first_fail_pat, 0);
    check({tag, "_busy"}, bus1.busy, 0);
    check({tag, "_done"}, bus1.done, 0);
    check({tag, "_rv"},   bus1.result_valid, 0);
    check({tag, "_pass"}, bus1.pass, 0);
  endtask

  task automatic set_flips(input int mode);
    for (int p = 0; p < NPAT; p++) begin
      if (mode == 0) flip[p] = 2'b00;
      else flip[p] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
  endtask

  // One dut1 run. restart_k >= 0 re-pulses start at that cycle; abort_k >= 0
  // aborts at that cycle (must be an APPLY or SETTLE cycle).
  task automatic run1(input string tag, input int restart_k, input int abort_k,
                      input bit good_golden);
    logic [15:0] msig;
    int mf, mfirst, k, sched_err, exp_pat, spp, dcnt;
    spp = 3;
    model(msig, mf, mfirst);
    bus1.golden_sig = good_golden ? msig : (msig ^ 16'($urandom_range(1, 65535)));
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    k = 0;
    sched_err = 0;
    while (!bus1.done && k < 200) begin
      exp_pat = (k / spp < NPAT) ? k / spp : NPAT - 1;
      if (bus1.pat !== 3'(exp_pat) || bus1.busy !== (k < NPAT * spp)) sched_err++;
      bus1.start = (k == restart_k);
      if (k == abort_k) begin
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        check({tag, "_ab_busy"}, bus1.busy, 0);
        check({tag, "_ab_rv"},   bus1.result_valid, 0);
        check({tag, "_ab_pat"},  bus1.pat, exp_pat);
        check({tag, "_ab_fcnt"}, bus1.fail_cnt, flips_below(exp_pat));
        check({tag, "_ab_sched"}, sched_err, 0);
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
          if (bus1.done || bus1.busy) dcnt++;
          @(negedge clk);
        end
        check({tag, "_ab_quiet"}, dcnt, 0);
        return;
      end
      @(negedge clk);
      k++;
    end
    bus1.start = 1'b0;
    check({tag, "_lat"},   k, NPAT * spp + 1);
    check({tag, "_sched"}, sched_err, 0);
    check({tag, "_rv"},    bus1.result_valid, 1);
    check({tag, "_fcnt"},  bus1.fail_cnt, mf);
    check({tag, "_ffv"},   bus1.first_fail_valid, (mf > 0));
    if (mf > 0) check({tag, "_ffp"}, bus1.first_fail_pat, mfirst);
    check({tag, "_sig"},   bus1.signature, msig);
    check({tag, "_pass"},  bus1.pass, (good_golden && mf == 0));
    @(negedge clk);
    check({tag, "_done1"}, bus1.done, 0);
    check({tag, "_hold"},  bus1.result_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] msig;
    int mf, mfirst, k;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.golden_sig = '0;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.golden_sig = '0;
    set_flips(0);
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    set_flips(0);
    run1("clean", -1, -1, 1'b1);

    set_flips(0);
    flip[5] = 2'($urandom_range(1, 3));
    flip[6] = 2'($urandom_range(1, 3));
    run1("f56", -1, -1, 1'b1);

    for (int i = 0; i < 3; i++) begin
      set_flips(1);
      run1("rnd", -1, -1, 1'($urandom_range(0, 1)));
    end

    set_flips(0);
    run1("badgold", -1, -1, 1'b0);

    set_flips(1);
    run1("ab4", -1, 3 * 4 + 1, 1'b1);
    set_flips(0);
    run1("afterab", -1, -1, 1'b1);

    set_flips(1);
    run1("abrnd", -1, 3 * $urandom_range(0, NPAT - 1) + $urandom_range(0, 1), 1'b1);

    set_flips(1);
    run1("restart", $urandom_range(1, 20), -1, 1'b1);

    // start and abort together in IDLE: nothing may start.
    @(negedge clk);
    bus1.start = 1'b1; bus1.abort = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus1.abort = 1'b0;
    check("sa_busy", bus1.busy, 0);
    check("sa_rv",   bus1.result_valid, 1);
    @(negedge clk);
    check("sa_busy2", bus1.busy, 0);

    // Reset in the middle of a run.
    set_flips(1);
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    repeat (10) @(negedge clk);
    check("prerst_pat", bus1.pat, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    set_flips(0);
    run1("postrst", -1, -1, 1'b1);

    // No-settle sequencer: 2 cycles per pattern, same signature.
    set_flips(0);
    model(msig, mf, mfirst);
    bus0.golden_sig = msig;
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk) bus0.start = 1'b0;
    k = 0;
    while (!bus0.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("s0_lat",  k, NPAT * 2 + 1);
    check("s0_sig",  bus0.signature, msig);
    check("s0_fcnt", bus0.fail_cnt, 0);
    check("s0_pass", bus0.pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
